// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the ready/valid pipeline stage buffer.
//   occ_t        - occupancy / state encoding of the stage (EMPTY, ONE, TWO)
//   PIPE_DATA_W  - default payload width
//   PIPE_CTRL_W  - default control width
//   CTRL_BUBBLE  - control value presented whenever no valid beat is held
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 8;

  localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one {valid, data, ctrl} holding register of the stage.
//   clk, rst_n - clock and asynchronous active-low reset (clears everything)
//   load_i     - capture data_i/ctrl_i and mark valid (wins over clear_i)
//   clear_i    - drop the entry: valid=0, ctrl=bubble, data keeps its last value
//   data_i     - payload to capture
//   ctrl_i     - control bits to capture
//   vld_o      - entry holds a beat
//   data_o     - held payload
//   ctrl_o     - held control bits (bubble when not valid)
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= CTRL_W'(CTRL_BUBBLE);
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end else if (clear_i) begin
      // Data is deliberately left alone; only the write-enable class bits
      // must read as a bubble.
      vld_q  <= 1'b0;
      ctrl_q <= CTRL_W'(CTRL_BUBBLE);
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised ready/valid pipeline stage register.
// DATA passes unchanged, CTRL is forced to zero on bubbles. Flush squashes
// every held beat and any beat accepted in the flush cycle.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   - 2-entry (main + skid) buffer, in_ready registered
//   undefined - single entry, in_ready = !out_valid || out_ready
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - squash all held beats and this cycle's accept
//   in_valid/in_ready    - upstream handshake
//   in_data/in_ctrl      - upstream payload / control
//   out_valid/out_ready  - downstream handshake
//   out_data/out_ctrl    - head entry payload / control (ctrl=0 when !out_valid)
//   occupancy            - held beats, 0..2
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  occ_t occ_q, occ_d;
  logic run_q;
  logic acc, dlv;

  logic              main_ld, main_clr, main_vld;
  logic [DATA_W-1:0] main_din, main_data;
  logic [CTRL_W-1:0] main_cin, main_ctrl;

  // Blocks an accept on the very edge that releases reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q;
  logic              skid_ld, skid_clr, skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready = in_ready_q;

  // A valid skid entry is always older than anything upstream, so it has
  // first claim on main.
  assign main_din = skid_vld ? skid_data : in_data;
  assign main_cin = skid_vld ? skid_ctrl : in_ctrl;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_ld),
    .clear_i(skid_clr),
    .data_i (in_data),
    .ctrl_i (in_ctrl),
    .vld_o  (skid_vld),
    .data_o (skid_data),
    .ctrl_o (skid_ctrl)
  );
`else
  // Single entry: a beat may enter while the held one leaves.
  assign in_ready = !main_vld || out_ready;
  assign main_din = in_data;
  assign main_cin = in_ctrl;
`endif

  assign acc = in_valid && in_ready && run_q;
  assign dlv = main_vld && out_ready;

  always_comb begin
    occ_d    = occ_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
`endif
    if (flush) begin
      occ_d    = OCC_EMPTY;
      main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (acc) begin
            main_ld = 1'b1;
            occ_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && dlv) begin
            main_ld = 1'b1;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (acc) begin
            skid_ld = 1'b1;
            occ_d   = OCC_TWO;
          end
`endif
          else if (dlv) begin
            main_clr = 1'b1;
            occ_d    = OCC_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        OCC_TWO: begin
          if (dlv) begin
            main_ld  = 1'b1;
            skid_clr = 1'b1;
            occ_d    = OCC_ONE;
          end
        end
`endif
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q <= 1'b1;
`endif
    end else begin
      occ_q      <= occ_d;
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q <= (occ_d != OCC_TWO);
`endif
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_ld),
    .clear_i(main_clr),
    .data_i (main_din),
    .ctrl_i (main_cin),
    .vld_o  (main_vld),
    .data_o (main_data),
    .ctrl_o (main_ctrl)
  );

  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus random traffic, checked by
// a FIFO reference model (expected beats queue) and a separate monitor.
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];

  pipe_stage_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of upstream/downstream drive. Inputs change at negedge, the
  // handshake is judged 1 time unit before the posedge, and the task returns
  // 1 time unit after that posedge.
  task automatic step(input logic v, input logic [31:0] d, input logic [7:0] c,
                      input logic ordy, input logic fl, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #4;
    acc = v && in_ready && rst_n;
    if (acc && !fl) exp_q.push_back('{c: c, d: d});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    logic a;
    for (int k = 0; k < budget && (exp_q.size() != 0 || out_valid); k++)
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, a);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: delivery compare against the model head, flush empties the
  // model, and after each edge the visible state must match the model.
  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h ctrl %0h expected none", out_data, out_ctrl);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
      end
    end
    if (rst_n && flush) exp_q.delete();
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
`ifdef PIPE_STAGE_SKID_EN
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
`else
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0 || out_ready));
`endif
      if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] beats[3];
    int          cur;
    beats[0] = 32'hA; beats[1] = 32'hB; beats[2] = 32'hC;

    // Reset values, no clock edge needed.
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (2) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, acc);

    // Streaming: one beat per cycle, latency 1.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 8'h05, 1'b1, 1'b0, acc);
      chk("stream_acc", 64'(acc), 64'd1);
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_data), 64'(i));
    end
    drain(10);

    // Stall: upstream holds its beat until accepted.
    cur = 0;
    repeat (4) begin
      step(1'b1, beats[cur], 8'h05, 1'b0, 1'b0, acc);
      if (acc) cur++;
    end
    chk("stall_occ", 64'(occupancy), 64'(CAP));
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_accepted", 64'(cur), 64'(CAP));
    for (int k = 0; k < 20 && cur < 3; k++) begin
      step(1'b1, beats[cur], 8'h05, 1'b1, 1'b0, acc);
      if (acc) cur++;
    end
    chk("stall_all_accepted", 64'(cur), 64'd3);
    drain(20);

    // Async reset while full.
    repeat (2) step(1'b1, 32'h55, 8'h0F, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (2) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, acc);

    // Flush while full, with a beat offered in the flush cycle.
    step(1'b1, 32'h11, 8'h33, 1'b0, 1'b0, acc);
    step(1'b1, 32'h12, 8'h33, 1'b0, 1'b0, acc);
    step(1'b1, 32'hD, 8'h33, 1'b0, 1'b1, acc);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    repeat (3) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, acc);

    // Accept and deliver together in ONE.
    step(1'b1, 32'h21, 8'h03, 1'b0, 1'b0, acc);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h22 + 32'(k), 8'h03, 1'b1, 1'b0, acc);
      chk("ad_acc", 64'(acc), 64'd1);
      chk("ad_occ", 64'(occupancy), 64'd1);
    end
    drain(10);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom, 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), acc);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
